// File: rtl/bus_master_if_if.sv
// Signal bundle between a CPU stage, its local SPM port and the shared bus.
// The master modport is the bus interface unit's view; slave is the environment's.
interface bus_master_if_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              stall;
    logic              flush;
    logic              busy;
    logic [ADDR_W-1:0] addr;
    logic              as_;
    logic              rw;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;

    logic [DATA_W-1:0] spm_rd_data;
    logic [ADDR_W-1:0] spm_addr;
    logic              spm_as_;
    logic              spm_rw;
    logic [DATA_W-1:0] spm_wr_data;

    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy_;
    logic              bus_grnt_;
    logic              bus_req_;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_as_;
    logic              bus_rw;
    logic [DATA_W-1:0] bus_wr_data;

    modport master (
        input  stall, flush, addr, as_, rw, wr_data,
        output busy, rd_data,
        input  spm_rd_data,
        output spm_addr, spm_as_, spm_rw, spm_wr_data,
        input  bus_rd_data, bus_rdy_, bus_grnt_,
        output bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );

    modport slave (
        output stall, flush, addr, as_, rw, wr_data,
        input  busy, rd_data,
        output spm_rd_data,
        input  spm_addr, spm_as_, spm_rw, spm_wr_data,
        output bus_rd_data, bus_rdy_, bus_grnt_,
        input  bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data
    );
endinterface

// File: rtl/bus_master_if.sv
// Initiator-side bus unit: zero-wait SPM path, full request/grant/strobe/ready
// protocol for every other address, busy stalls the pipeline until data.
module bus_master_if #(
    parameter logic [2:0] SPM_INDEX = 3'h1,
    parameter int         ADDR_W    = 30,
    parameter int         DATA_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    bus_master_if_if.master  bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACCESS,
        S_WAIT
    } state_t;

    state_t            state_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              as_q;
    logic              rw_q;
    logic [DATA_W-1:0] wd_q;
    logic [DATA_W-1:0] rd_buf_q;

    logic              spm_hit;
    logic              busy;
    logic [DATA_W-1:0] rd_data;
    logic              spm_as;

    assign spm_hit = (bus.addr[ADDR_W-1 -: 3] == SPM_INDEX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b1;
            addr_q   <= '0;
            as_q     <= 1'b1;
            rw_q     <= 1'b1;
            wd_q     <= '0;
            rd_buf_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.flush && !bus.as_ && !spm_hit) begin
                        req_q   <= 1'b0;
                        addr_q  <= bus.addr;
                        rw_q    <= bus.rw;
                        if (!bus.rw) wd_q <= bus.wr_data;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (!bus.bus_grnt_) begin
                        as_q    <= 1'b0;
                        state_q <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // strobe is only ever one cycle wide
                    as_q <= 1'b1;
                    if (!bus.bus_rdy_) begin
                        req_q    <= 1'b1;
                        addr_q   <= '0;
                        rw_q     <= 1'b1;
                        wd_q     <= '0;
                        rd_buf_q <= bus.bus_rd_data;
                        state_q  <= bus.stall ? S_WAIT : S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (!bus.stall) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy    = 1'b0;
        rd_data = '0;
        spm_as  = 1'b1;
        if (reset) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!bus.flush && !bus.as_) begin
                        if (spm_hit) begin
                            spm_as  = 1'b0;
                            rd_data = bus.spm_rd_data;
                        end else begin
                            busy = 1'b1;
                        end
                    end
                end
                S_REQ: busy = 1'b1;
                S_ACCESS: begin
                    if (!bus.bus_rdy_) rd_data = bus.bus_rd_data;
                    else               busy    = 1'b1;
                end
                S_WAIT: rd_data = rd_buf_q;
                default: busy = 1'b0;
            endcase
        end
    end

    assign bus.busy        = busy;
    assign bus.rd_data     = rd_data;
    assign bus.spm_addr    = bus.addr;
    assign bus.spm_as_     = spm_as;
    assign bus.spm_rw      = bus.rw;
    assign bus.spm_wr_data = bus.wr_data;
    assign bus.bus_req_    = req_q;
    assign bus.bus_addr    = addr_q;
    assign bus.bus_as_     = as_q;
    assign bus.bus_rw      = rw_q;
    assign bus.bus_wr_data = wd_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Bench for bus_master_if: directed plan steps plus random SPM and bus
// accesses checked against a latency/data model of the protocol.
module tb_bus_master_if;

    localparam int AW = 30;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    bus_master_if_if #(.ADDR_W(AW), .DATA_W(DW)) bi();

    bus_master_if #(
        .SPM_INDEX(3'h1),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bi)
    );

    int npass = 0;
    int nfail = 0;
    int ntot  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [29:0] bus_addr_rnd();
        logic [29:0] a;
        a = 30'($urandom);
        if (a[29:27] == 3'h1) a[29] = 1'b1;
        return a;
    endfunction

    function automatic logic [29:0] spm_addr_rnd();
        logic [29:0] a;
        a = 30'($urandom);
        a[29:27] = 3'h1;
        return a;
    endfunction

    task automatic chk_idle_regs(string tag);
        chk({tag, "_req"},  32'(bi.bus_req_), 32'd1);
        chk({tag, "_as"},   32'(bi.bus_as_), 32'd1);
        chk({tag, "_addr"}, 32'(bi.bus_addr), 32'd0);
        chk({tag, "_rw"},   32'(bi.bus_rw), 32'd1);
        chk({tag, "_wd"},   bi.bus_wr_data, 32'd0);
    endtask

    task automatic spm_access(
        input logic [29:0] a,
        input logic        rw,
        input logic [31:0] wd,
        input logic [31:0] sd
    );
        bi.as_ = 1'b0; bi.addr = a; bi.rw = rw;
        bi.wr_data = wd; bi.spm_rd_data = sd;
        bi.flush = 1'b0; bi.stall = 1'($urandom);
        mid();
        chk("spm_as",   32'(bi.spm_as_), 32'd0);
        chk("spm_busy", 32'(bi.busy), 32'd0);
        chk("spm_rd",   bi.rd_data, sd);
        chk("spm_addr", 32'(bi.spm_addr), 32'(a));
        chk("spm_rw",   32'(bi.spm_rw), 32'(rw));
        chk("spm_wd",   bi.spm_wr_data, wd);
        chk("spm_req",  32'(bi.bus_req_), 32'd1);
        nxt();
        bi.as_ = 1'b1; bi.stall = 1'b0;
        mid();
        chk("spm_after_req",  32'(bi.bus_req_), 32'd1);
        chk("spm_after_busy", 32'(bi.busy), 32'd0);
        nxt();
    endtask

    // g: REQ cycles before grant, r: ACCESS cycles before ready,
    // k: WAIT cycles (stall held across completion when k > 0)
    task automatic bus_access(
        input logic [29:0] a,
        input logic        rw,
        input logic [31:0] wd,
        input logic [31:0] rdat,
        input int          g,
        input int          r,
        input int          k,
        input logic        rflush
    );
        bi.as_ = 1'b0; bi.addr = a; bi.rw = rw; bi.wr_data = wd;
        bi.flush = 1'b0; bi.stall = 1'b0;
        bi.bus_grnt_ = 1'b1; bi.bus_rdy_ = 1'b1;
        bi.bus_rd_data = $urandom;
        mid();
        chk("iss_busy", 32'(bi.busy), 32'd1);
        chk("iss_spm",  32'(bi.spm_as_), 32'd1);
        chk("iss_req",  32'(bi.bus_req_), 32'd1);
        nxt();
        // CPU-side changes after issue must not disturb the transaction
        bi.as_ = 1'($urandom); bi.rw = 1'($urandom);
        bi.addr = ($urandom_range(0, 1) == 1) ? spm_addr_rnd() : bus_addr_rnd();
        bi.wr_data = $urandom;
        for (int i = 0; i <= g; i++) begin
            bi.bus_grnt_ = (i == g) ? 1'b0 : 1'b1;
            bi.bus_rdy_  = 1'($urandom);
            bi.flush = rflush ? 1'b1 : 1'($urandom);
            bi.stall = 1'($urandom);
            mid();
            chk("req_busy", 32'(bi.busy), 32'd1);
            chk("req_req",  32'(bi.bus_req_), 32'd0);
            chk("req_as",   32'(bi.bus_as_), 32'd1);
            chk("req_addr", 32'(bi.bus_addr), 32'(a));
            chk("req_rw",   32'(bi.bus_rw), 32'(rw));
            chk("req_spm",  32'(bi.spm_as_), 32'd1);
            nxt();
        end
        bi.bus_grnt_ = 1'b1;
        for (int j = 0; j <= r; j++) begin
            bi.bus_rdy_ = (j == r) ? 1'b0 : 1'b1;
            bi.bus_rd_data = (j == r) ? rdat : $urandom;
            bi.stall = (j == r) ? (k > 0) : 1'($urandom);
            bi.flush = 1'($urandom);
            mid();
            chk("acc_as",   32'(bi.bus_as_), (j == 0) ? 32'd0 : 32'd1);
            chk("acc_busy", 32'(bi.busy), (j == r) ? 32'd0 : 32'd1);
            chk("acc_req",  32'(bi.bus_req_), 32'd0);
            chk("acc_addr", 32'(bi.bus_addr), 32'(a));
            chk("acc_rw",   32'(bi.bus_rw), 32'(rw));
            chk("acc_wd",   bi.bus_wr_data, rw ? 32'd0 : wd);
            chk("acc_spm",  32'(bi.spm_as_), 32'd1);
            if (j == r) chk("acc_rd", bi.rd_data, rdat);
            nxt();
        end
        bi.bus_rdy_ = 1'b1;
        bi.bus_rd_data = $urandom;
        for (int i = 0; i < k; i++) begin
            bi.stall = (i < k - 1) ? 1'b1 : 1'b0;
            mid();
            chk("wait_busy", 32'(bi.busy), 32'd0);
            chk("wait_rd",   bi.rd_data, rdat);
            chk_idle_regs("wait");
            nxt();
        end
        bi.stall = 1'b0; bi.as_ = 1'b1; bi.flush = 1'b0;
        mid();
        chk("end_busy", 32'(bi.busy), 32'd0);
        chk("end_rd",   bi.rd_data, 32'd0);
        chk_idle_regs("end");
        nxt();
    endtask

    initial begin
        reset = 1'b0;
        bi.stall = 1'b0; bi.flush = 1'b0;
        bi.as_ = 1'b0; bi.addr = 30'h0800_0010; bi.rw = 1'b1;
        bi.wr_data = 32'h0; bi.spm_rd_data = 32'h5555_AAAA;
        bi.bus_rd_data = 32'h0; bi.bus_rdy_ = 1'b0; bi.bus_grnt_ = 1'b0;
        #12;
        chk("rst_busy", 32'(bi.busy), 32'd0);
        chk("rst_rd",   bi.rd_data, 32'd0);
        chk("rst_spm",  32'(bi.spm_as_), 32'd1);
        chk_idle_regs("rst");
        mid();
        reset = 1'b1;
        bi.as_ = 1'b1; bi.bus_rdy_ = 1'b1; bi.bus_grnt_ = 1'b1;
        nxt();

        // directed steps
        spm_access(30'h0800_0010, 1'b1, 32'h0, 32'hCAFE_0001);
        bus_access(30'h0000_0040, 1'b1, 32'h0, 32'h1234_5678, 2, 3, 0, 1'b0);
        bus_access(30'h1000_0004, 1'b0, 32'hDEAD_BEEF, 32'h0BAD_F00D,
                   0, 0, 0, 1'b0);
        bus_access(30'h0000_0080, 1'b1, 32'h0, 32'hA5A5_0003, 1, 1, 3, 1'b0);

        // flush in IDLE blocks both paths
        bi.as_ = 1'b0; bi.addr = 30'h0000_0100; bi.rw = 1'b1; bi.flush = 1'b1;
        mid();
        chk("fl_busy", 32'(bi.busy), 32'd0);
        chk("fl_rd",   bi.rd_data, 32'd0);
        chk("fl_spm",  32'(bi.spm_as_), 32'd1);
        nxt();
        bi.addr = 30'h0800_0020;
        mid();
        chk("fl_spm2", 32'(bi.spm_as_), 32'd1);
        chk("fl_rd2",  bi.rd_data, 32'd0);
        chk("fl_req",  32'(bi.bus_req_), 32'd1);
        nxt();
        bi.flush = 1'b0; bi.as_ = 1'b1;
        mid();
        chk("fl_req2", 32'(bi.bus_req_), 32'd1);
        nxt();
        bus_access(30'h0000_0200, 1'b1, 32'h0, 32'h7777_0001, 2, 1, 0, 1'b1);

        // asynchronous reset during the strobe cycle
        bi.as_ = 1'b0; bi.addr = 30'h0000_0300; bi.rw = 1'b1;
        bi.bus_grnt_ = 1'b1; bi.bus_rdy_ = 1'b1;
        nxt();
        bi.as_ = 1'b0; bi.addr = 30'h0800_0044; bi.bus_grnt_ = 1'b0;
        nxt();
        bi.bus_grnt_ = 1'b1;
        mid();
        chk("ra_as_pre", 32'(bi.bus_as_), 32'd0);
        #2;
        reset = 1'b0; bi.bus_rdy_ = 1'b0; bi.bus_rd_data = 32'hFFFF_0000;
        #1;
        chk("ra_req",  32'(bi.bus_req_), 32'd1);
        chk("ra_as",   32'(bi.bus_as_), 32'd1);
        chk("ra_busy", 32'(bi.busy), 32'd0);
        chk("ra_rd",   bi.rd_data, 32'd0);
        chk("ra_spm",  32'(bi.spm_as_), 32'd1);
        chk("ra_addr", 32'(bi.bus_addr), 32'd0);
        nxt();
        bi.as_ = 1'b1; bi.bus_rdy_ = 1'b1;
        mid();
        reset = 1'b1;
        nxt();
        bus_access(30'h0000_0400, 1'b1, 32'h0, 32'h1357_9BDF, 0, 2, 0, 1'b0);

        // random mix of SPM and bus traffic
        for (int n = 0; n < 40; n++) begin
            logic        rw;
            logic [31:0] wd;
            logic [31:0] rdv;
            int          k;
            rw  = 1'($urandom);
            wd  = $urandom;
            rdv = $urandom;
            k   = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0;
            if ($urandom_range(0, 2) == 0)
                spm_access(spm_addr_rnd(), rw, wd, rdv);
            else
                bus_access(bus_addr_rnd(), rw, wd, rdv,
                           $urandom_range(0, 3), $urandom_range(0, 3), k,
                           1'($urandom));
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/bus_master_if.md
Name: bus_master_if

Overview:
- Initiator-side bus interface unit between one CPU pipeline stage (IF or MEM) and the shared bus.
- Addresses decoding to the scratchpad (SPM) slave index go to the local SPM port directly with zero wait states.
- All other accesses run the full bus protocol: request, wait for grant, single-cycle address strobe, wait for slave ready, release.
- Raises busy to stall the pipeline until the data phase completes.

Parameters:
- SPM_INDEX, 3'h1, value of addr[29:27] that selects the local SPM path.
- ADDR_W, 30, word address width.
- DATA_W, 32, word data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- stall  in  1  pipeline stall.
- flush  in  1  pipeline flush.
- busy  out  1  access not yet complete; pipeline must stall.
- addr  in  ADDR_W  CPU word address.
- as_  in  1  CPU address strobe, active-low.
- rw  in  1  1 = READ, 0 = WRITE.
- wr_data  in  DATA_W  CPU write data.
- rd_data  out  DATA_W  read data to CPU.
- spm_rd_data  in  DATA_W  SPM read data.
- spm_addr  out  ADDR_W  SPM address.
- spm_as_  out  1  SPM strobe, active-low.
- spm_rw  out  1  SPM read/write.
- spm_wr_data  out  DATA_W  SPM write data.
- bus_rd_data  in  DATA_W  bus read data.
- bus_rdy_  in  1  slave ready, active-low.
- bus_grnt_  in  1  arbiter grant, active-low.
- bus_req_  out  1  bus request, active-low.
- bus_addr  out  ADDR_W  bus address.
- bus_as_  out  1  bus address strobe, active-low.
- bus_rw  out  1  bus read/write.
- bus_wr_data  out  DATA_W  bus write data.

Behaviour:
- Registered outputs: bus_req_, bus_addr, bus_as_, bus_rw, bus_wr_data, plus internal rd_buf and state.
- Reset values: bus_req_=1, bus_addr=0, bus_as_=1, bus_rw=1 (READ), bus_wr_data=0, rd_buf=0, state=IDLE.
- During reset, combinational outputs take the IDLE values with as_ deasserted: busy=0, rd_data=0, spm_as_=1.
- SPM path: spm_addr=addr, spm_rw=rw, spm_wr_data=wr_data always. spm_as_=0 only in IDLE when as_=0, flush=0 and addr[29:27]==SPM_INDEX; otherwise 1.
- IDLE:
  - flush=1 → no access started; busy=0; rd_data=0.
  - as_=0 and SPM hit → busy=0; rd_data=spm_rd_data in the same cycle.
  - as_=0 and no SPM hit → busy=1 this cycle. Next edge: bus_req_←0; bus_addr/bus_rw/bus_wr_data latch the CPU values (bus_wr_data latched only for WRITE); state←REQ.
  - as_=1 → busy=0; rd_data=0.
- REQ: busy=1.
  - bus_grnt_=0 → bus_as_←0; state←ACCESS.
  - bus_grnt_=1 → hold all outputs.
- ACCESS:
  - bus_as_←1 at the next edge, so the strobe is exactly 1 cycle wide.
  - bus_rdy_=1 → busy=1; wait.
  - bus_rdy_=0 → busy=0 and rd_data=bus_rd_data combinationally this cycle. Next edge: bus_req_←1, bus_addr←0, bus_rw←1, bus_wr_data←0, rd_buf←bus_rd_data. Then stall=1 → state←WAIT; stall=0 → state←IDLE.
  - bus_rdy_ is ignored outside ACCESS. A ready in the first ACCESS cycle (strobe still low) is legal.
- WAIT: busy=0; rd_data=rd_buf. When stall=0, state←IDLE.
- Minimum bus latency: issue cycle in IDLE + 1 REQ + 1 ACCESS = 3 cycles.
- flush has no effect outside IDLE. An in-flight bus transaction always completes, because the protocol has no abort.
- Changes to as_/addr/rw on the CPU side after IDLE are ignored until the bus returns to IDLE, since the transaction uses the latched copies.
- Reset asserted in any state forces the reset values asynchronously. The slave may see its strobe vanish mid-access; this is accepted under global reset.
- Write accesses: rd_data during ACCESS completion and in WAIT carries whatever bus_rd_data/rd_buf hold; the CPU ignores it.

Test Plan:
- SPM read: addr=30'h0800_0010 (index 1), as_=0, rw=1, spm_rd_data=32'hCAFE_0001 → same cycle spm_as_=0, busy=0, rd_data=32'hCAFE_0001; bus_req_ stays 1.
- Bus read with delays: addr=30'h0000_0040, grant 2 cycles after request, rdy_ 3 cycles after strobe, bus_rd_data=32'h1234_5678 → bus_req_ falls 1 cycle after issue; bus_as_=0 for exactly 1 cycle; busy=1 until the rdy_ cycle; rd_data=32'h1234_5678 in that cycle; bus_req_=1 next cycle.
- Bus write: addr=30'h1000_0004, rw=0, wr_data=32'hDEAD_BEEF, immediate grant and rdy_ → bus_wr_data=32'hDEAD_BEEF and bus_rw=0 while the strobe is low; total busy = 2 cycles (issue + REQ); outputs return to reset values after completion.
- Stall hold: bus read completes with stall=1 for 3 more cycles → state WAIT, busy=0, rd_data holds the captured word for all 3 cycles; return to IDLE on stall=0.
- Flush: flush=1 with as_=0 in IDLE (bus address) → no request, busy=0. flush=1 during REQ → transaction still completes normally.
- Reset mid-ACCESS: reset=0 while bus_as_=0 → bus_req_=1, bus_as_=1, busy=0 immediately without waiting for a clock edge. After release, a new read completes normally.
